trace_port_capture: RTL and testbench

Parametrised successor to the single-byte trace assembler. Captures a 1/2/4-bit TPIU trace port sampled on both traceClk edges. The dual-edge samples arrive as two pre-registered nibbles from the IO DDR primitive. The block locates the TPIU full-sync pattern at any bit offset and assembles byte-aligned data. Bytes are buffered in a FIFO with a valid/ready output for the downstream TPIU frame decoder. Everything runs in the traceClk domain; CDC to the system clock happens downstream.

---
 rtl/trace_port_capture.sv | 178 +++++++++++++++++
 tb/tb_trace_port_capture.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_port_capture.sv
// Dual-edge TPIU trace port capture: locates full-sync at any bit offset,
// assembles LSB-first bytes and queues them for the downstream frame decoder.
`timescale 1ns/1ps
module trace_port_capture #(
    parameter int FIFO_DEPTH = 16,
    parameter int SYNC_ONES  = 31
) (
    input  logic                        traceClk,
    input  logic                        rst,
    input  logic [3:0]                  traceDinA,
    input  logic [3:0]                  traceDinB,
    input  logic [1:0]                  width,
    input  logic                        clrOverflow,
    output logic [7:0]                  oByte,
    output logic                        oValid,
    input  logic                        iReady,
    output logic                        synced,
    output logic                        syncPulse,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = $clog2(SYNC_ONES + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(SYNC_ONES);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic {UNSYNC, SYNCED} state_t;

    function automatic logic [RW-1:0] satInc(input logic [RW-1:0] run);
        return (run == RUN_MAX) ? run : run + 1'b1;
    endfunction

    logic [3:0] dinA_p0, dinB_p0;
    logic [1:0] width_p0;
    logic       vld_p0;

    // Stage 1: register the DDR nibbles and the normalised port width
    always_ff @(posedge traceClk or posedge rst) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            width_p0 <= 2'd0;
        end else begin
            vld_p0   <= 1'b1;
            width_p0 <= (width == 2'd3) ? 2'd2 : width;
        end
    end

    always_ff @(posedge traceClk) begin
        dinA_p0 <= traceDinA;
        dinB_p0 <= traceDinB;
    end

    logic [7:0] streamBits, streamMask;

    always_comb begin
        streamBits = {dinB_p0, dinA_p0};
        streamMask = 8'hFF;
        case (width_p0)
            2'd0: begin
                streamBits = {6'd0, dinB_p0[0], dinA_p0[0]};
                streamMask = 8'h03;
            end
            2'd1: begin
                streamBits = {4'd0, dinB_p0[1:0], dinA_p0[1:0]};
                streamMask = 8'h0F;
            end
            default: ;
        endcase
    end

    state_t        state;
    logic [RW-1:0] onesRun, runN;
    logic [7:0]    acc, accN, byteN, byte_p1;
    logic [2:0]    accCnt, cntN;
    logic [1:0]    widthPrev;
    logic          syncN, detN, pushN, take, push_p1;

    // Stage 2: walk the cycle's bits in stream order; a sync landing on a full
    // byte boundary (7 bits pending) just completes the 7F byte normally
    always_comb begin
        runN  = onesRun;
        accN  = acc;
        cntN  = accCnt;
        syncN = (state == SYNCED);
        detN  = 1'b0;
        pushN = 1'b0;
        byteN = acc;
        take  = 1'b0;
        if (vld_p0 && (width_p0 != widthPrev)) begin
            runN  = '0;
            accN  = '0;
            cntN  = '0;
            syncN = 1'b0;
        end else if (vld_p0) begin
            for (int i = 0; i < 8; i++) begin
                if (streamMask[i]) begin
                    take = syncN;
                    if (!streamBits[i] && (runN == RUN_MAX)) begin
                        detN = 1'b1;
                        if (!(syncN && (cntN == 3'd7))) begin
                            take = 1'b0;
                            accN = '0;
                            cntN = '0;
                        end
                        syncN = 1'b1;
                    end
                    runN = streamBits[i] ? satInc(runN) : '0;
                    if (take) begin
                        accN[cntN] = streamBits[i];
                        if (cntN == 3'd7) begin
                            pushN = 1'b1;
                            byteN = accN;
                            accN  = '0;
                        end
                        cntN = cntN + 3'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge traceClk or posedge rst) begin
        if (rst) begin
            state     <= UNSYNC;
            onesRun   <= '0;
            acc       <= '0;
            accCnt    <= '0;
            widthPrev <= 2'd0;
            syncPulse <= 1'b0;
            push_p1   <= 1'b0;
        end else begin
            state     <= syncN ? SYNCED : UNSYNC;
            onesRun   <= runN;
            acc       <= accN;
            accCnt    <= cntN;
            widthPrev <= width_p0;
            syncPulse <= detN;
            push_p1   <= pushN;
        end
    end

    always_ff @(posedge traceClk) begin
        byte_p1 <= byteN;
    end

    assign synced = (state == SYNCED);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic          full, pop, wrEn, drop;

    assign oValid = (level != '0);
    assign full   = (level == DEPTH_L);
    assign pop    = oValid && iReady;
    assign wrEn   = push_p1 && (!full || pop);
    assign drop   = push_p1 && full && !pop;
    assign oByte  = oValid ? mem[rdPtr] : 8'h00;

    // Stage 3: show-ahead byte FIFO
    always_ff @(posedge traceClk) begin
        if (wrEn) mem[wrPtr] <= byte_p1;
    end

    always_ff @(posedge traceClk or posedge rst) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wrEn) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            level    <= level + LW'(wrEn) - LW'(pop);
            overflow <= drop | (overflow & ~clrOverflow);
        end
    end
endmodule

// File: tb/tb_trace_port_capture.sv
// Bench for trace_port_capture: directed scenarios plus randomized streams
// compared cycle by cycle against a bit-level behavioural model.
`timescale 1ns/1ps
module tb_trace_port_capture;
    localparam int DEPTH = 16;
    localparam int SONES = 31;

    logic       traceClk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] traceDinA = '0, traceDinB = '0;
    logic [1:0] width = '0;
    logic       clrOverflow = 1'b0, iReady = 1'b0;
    logic [7:0] oByte;
    logic       oValid, synced, syncPulse, overflow;
    logic [4:0] level;

    trace_port_capture #(.FIFO_DEPTH(DEPTH), .SYNC_ONES(SONES)) dut (
        .traceClk(traceClk), .rst(rst), .traceDinA(traceDinA), .traceDinB(traceDinB),
        .width(width), .clrOverflow(clrOverflow), .oByte(oByte), .oValid(oValid),
        .iReady(iReady), .synced(synced), .syncPulse(syncPulse), .overflow(overflow),
        .level(level)
    );

    always #5 traceClk = ~traceClk;

    int nAssert = 0, nFail = 0, pulseCnt = 0;
    int mRun, mPrevW;
    bit mSynced, mOvf;
    bit mAcc[$];
    bit txq[$];
    logic [7:0] mq[$];
    logic [7:0] rxLog[$];
    bit det1, syn1, push1, push2;
    logic [7:0] byte1, byte2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rxAt(input int i);
        return (i < rxLog.size()) ? {24'd0, rxLog[i]} : 32'hFFFF_FFFF;
    endfunction

    // Reference: one cycle of 2w stream bits against the sync/assembly rules
    task automatic modelCycle(input logic [3:0] a, input logic [3:0] b, input logic [1:0] wc,
                              output bit det, output bit syn, output bit psh, output logic [7:0] by);
        int w, we;
        bit bt;
        we = (wc == 2'd3) ? 2 : int'(wc);
        w = (we == 0) ? 1 : (we == 1) ? 2 : 4;
        det = 0; psh = 0; by = 8'h00;
        if (we != mPrevW) begin
            mPrevW = we; mSynced = 0; mRun = 0; mAcc.delete();
            syn = 0;
            return;
        end
        for (int i = 0; i < 2 * w; i++) begin
            bt = (i < w) ? a[i] : b[i - w];
            if (!bt && mRun >= SONES) begin
                det = 1;
                if (!(mSynced && mAcc.size() == 7)) begin
                    mAcc.delete(); mSynced = 1; mRun = 0;
                    continue;
                end
            end
            mRun = bt ? ((mRun < SONES) ? mRun + 1 : SONES) : 0;
            if (mSynced) begin
                mAcc.push_back(bt);
                if (mAcc.size() == 8) begin
                    for (int j = 0; j < 8; j++) by[j] = mAcc[j];
                    psh = 1;
                    mAcc.delete();
                end
            end
        end
        syn = mSynced;
    endtask

    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [1:0] wc,
                        input bit rdy, input bit clr);
        bit d, s, p, popM, expPulse, expSyn;
        logic [7:0] by;
        traceDinA = a; traceDinB = b; width = wc; iReady = rdy; clrOverflow = clr;
        #1;
        if (oValid && iReady) rxLog.push_back(oByte);
        popM = rdy && (mq.size() > 0);
        modelCycle(a, b, wc, d, s, p, by);
        @(posedge traceClk);
        if (popM) void'(mq.pop_front());
        if (clr) mOvf = 0;
        if (push2) begin
            if (mq.size() < DEPTH) mq.push_back(byte2);
            else mOvf = 1;
        end
        expPulse = det1; expSyn = syn1;
        push2 = push1; byte2 = byte1;
        det1 = d; syn1 = s; push1 = p; byte1 = by;
        #1;
        check("syncPulse", {31'd0, syncPulse}, {31'd0, expPulse});
        check("synced", {31'd0, synced}, {31'd0, expSyn});
        check("oValid", {31'd0, oValid}, (mq.size() > 0) ? 32'd1 : 32'd0);
        check("level", {27'd0, level}, mq.size());
        check("oByte", {24'd0, oByte}, (mq.size() > 0) ? {24'd0, mq[0]} : 32'd0);
        check("overflow", {31'd0, overflow}, {31'd0, mOvf});
        if (syncPulse) pulseCnt++;
    endtask

    task automatic doReset();
        @(negedge traceClk); #2;
        rst = 1'b1;
        traceDinA = '0; traceDinB = '0; width = '0; iReady = 1'b0; clrOverflow = 1'b0;
        #1;
        check("rst_oValid", {31'd0, oValid}, 0);
        check("rst_oByte", {24'd0, oByte}, 0);
        check("rst_synced", {31'd0, synced}, 0);
        check("rst_syncPulse", {31'd0, syncPulse}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        check("rst_level", {27'd0, level}, 0);
        mRun = 0; mPrevW = 0; mSynced = 0; mOvf = 0;
        mAcc.delete(); mq.delete(); rxLog.delete(); txq.delete();
        det1 = 0; syn1 = 0; push1 = 0; push2 = 0; byte1 = 0; byte2 = 0;
        pulseCnt = 0;
        @(posedge traceClk);
        @(negedge traceClk);
        rst = 1'b0;
    endtask

    task automatic qByte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) txq.push_back(v[i]);
    endtask

    task automatic qSync();
        qByte(8'hFF); qByte(8'hFF); qByte(8'hFF); qByte(8'h7F);
    endtask

    // rmode: 0 = iReady low, 1 = iReady high, 2 = random iReady
    task automatic sendQ(input logic [1:0] wc, input int rmode);
        int w;
        logic [3:0] a, b;
        bit r;
        w = (wc == 2'd0) ? 1 : (wc == 2'd1) ? 2 : 4;
        while (txq.size() % (2 * w) != 0) txq.push_back(1'b0);
        while (txq.size() > 0) begin
            a = '0; b = '0;
            for (int i = 0; i < w; i++) a[i] = txq.pop_front();
            for (int i = 0; i < w; i++) b[i] = txq.pop_front();
            r = (rmode == 2) ? bit'($urandom_range(0, 1)) : (rmode == 1);
            step(a, b, wc, r, 1'b0);
        end
    endtask

    task automatic flush(input logic [1:0] wc, input int n, input bit rdy);
        repeat (n) step(4'h0, 4'h0, wc, rdy, 1'b0);
    endtask

    initial begin
        logic [1:0] wc;
        int sel, nj;

        // 4-bit port: sync then A5, 3C
        doReset();
        step(4'h0, 4'h0, 2'd2, 1'b1, 1'b0);
        repeat (3) step(4'hF, 4'hF, 2'd2, 1'b1, 1'b0);
        step(4'hF, 4'h7, 2'd2, 1'b1, 1'b0);
        step(4'h5, 4'hA, 2'd2, 1'b1, 1'b0);
        step(4'hC, 4'h3, 2'd2, 1'b1, 1'b0);
        flush(2'd1, 4, 1'b1);
        check("t1_pulses", pulseCnt, 1);
        check("t1_count", rxLog.size(), 2);
        check("t1_byte0", rxAt(0), 32'hA5);
        check("t1_byte1", rxAt(1), 32'h3C);

        // 1-bit port: sync at odd offset after junk
        doReset();
        step(4'h0, 4'h0, 2'd0, 1'b1, 1'b0);
        txq.push_back(1'b1); txq.push_back(1'b0); txq.push_back(1'b1);
        qSync(); qByte(8'h96);
        sendQ(2'd0, 1);
        flush(2'd2, 4, 1'b1);
        check("t2_pulses", pulseCnt, 1);
        check("t2_count", rxLog.size(), 1);
        check("t2_byte0", rxAt(0), 32'h96);

        // Realign while synced: partial bits discarded
        doReset();
        step(4'h0, 4'h0, 2'd2, 1'b1, 1'b0);
        qSync(); qByte(8'h11);
        txq.push_back(1'b1); txq.push_back(1'b0); txq.push_back(1'b1);
        qSync(); qByte(8'h5A);
        sendQ(2'd2, 1);
        flush(2'd1, 4, 1'b1);
        check("t3_pulses", pulseCnt, 2);
        check("t3_count", rxLog.size(), 6);
        check("t3_byte0", rxAt(0), 32'h11);
        check("t3_byte1", rxAt(1), 32'hFD);
        check("t3_byte4", rxAt(4), 32'hFF);
        check("t3_byte5", rxAt(5), 32'h5A);

        // Overflow: 17 bytes into a 16-deep FIFO
        doReset();
        step(4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
        qSync();
        for (int i = 0; i < 17; i++) qByte(8'(i));
        sendQ(2'd0, 0);
        flush(2'd0, 2, 1'b0);
        check("t4_level", {27'd0, level}, 16);
        check("t4_overflow", {31'd0, overflow}, 1);
        check("t4_head", {24'd0, oByte}, 0);
        flush(2'd2, 20, 1'b1);
        check("t4_count", rxLog.size(), 16);
        for (int i = 0; i < 16; i++) check("t4_drain", rxAt(i), i);
        step(4'h0, 4'h0, 2'd2, 1'b1, 1'b1);
        check("t4_clr", {31'd0, overflow}, 0);

        // Width change drops sync until a fresh sync at the new width
        doReset();
        step(4'h0, 4'h0, 2'd2, 1'b1, 1'b0);
        qSync(); qByte(8'h33);
        sendQ(2'd2, 1);
        qByte(8'h55); qByte(8'h55); qByte(8'h55);
        sendQ(2'd1, 1);
        check("t5_unsynced", {31'd0, synced}, 0);
        qSync(); qByte(8'hC3); qByte(8'h7E);
        sendQ(2'd1, 1);
        check("t5_resynced", {31'd0, synced}, 1);
        flush(2'd2, 4, 1'b1);
        check("t5_count", rxLog.size(), 3);
        check("t5_byte0", rxAt(0), 32'h33);
        check("t5_byte1", rxAt(1), 32'hC3);
        check("t5_byte2", rxAt(2), 32'h7E);

        // Async reset mid-byte with five bytes queued
        doReset();
        step(4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
        qSync();
        for (int i = 0; i < 5; i++) qByte(8'hA0 + 8'(i));
        txq.push_back(1'b1); txq.push_back(1'b1);
        sendQ(2'd0, 0);
        flush(2'd0, 2, 1'b0);
        check("t6_level", {27'd0, level}, 5);
        doReset();
        qByte(8'h55); qByte(8'h55); qByte(8'h55); qByte(8'h55);
        sendQ(2'd0, 1);
        check("t6_count", rxLog.size(), 0);
        check("t6_synced", {31'd0, synced}, 0);

        // Randomized streams with stray and realigning syncs, random back-pressure
        for (int t = 0; t < 4; t++) begin
            wc = 2'($urandom_range(0, 3));
            doReset();
            step(4'h0, 4'h0, wc, 1'b1, 1'b0);
            qSync();
            for (int k = 0; k < 24; k++) begin
                sel = $urandom_range(0, 9);
                if (sel == 0) qSync();
                else if (sel == 1) begin
                    nj = $urandom_range(1, 7);
                    for (int j = 0; j < nj; j++) txq.push_back(bit'($urandom_range(0, 1)));
                    qSync();
                end else qByte(8'($urandom));
            end
            sendQ(wc, 2);
            flush((wc == 2'd0) ? 2'd1 : 2'd0, 40, 1'b1);
            check("rand_drained", {27'd0, level}, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
